// File: rtl/ram_if.sv
// Bus bundle for the 512x32 single-port RAM. The shared data bus is resolved
// here from the two possible drivers: the RAM during a read, the master during a write.
interface ram_if #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 32
);
   logic                  re;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;

   // per-side drive enables and values feeding the shared bus
   logic                  ram_oe;
   logic [DATA_WIDTH-1:0] ram_dout;
   logic                  mst_oe;
   logic [DATA_WIDTH-1:0] mst_dout;

   wire  [DATA_WIDTH-1:0] data;

   // bus resolution: whoever has its enable up owns the wires, else high-Z
   assign data = ram_oe ? ram_dout :
                 mst_oe ? mst_dout : {DATA_WIDTH{1'bz}};

   modport master (
      output re, we, addr, mst_oe, mst_dout,
      input  data, ram_oe
   );

   modport slave (
      input  re, we, addr, data,
      output ram_oe, ram_dout
   );
endinterface

// File: rtl/ram.sv
// Single-port synchronous word store on a shared tri-state data bus.
// Writes take priority over reads; the RAM drives the bus only while re=1, we=0.
module ram #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2**ADDR_WIDTH
) (
   input logic clk,
   input logic rst,
   ram_if.slave bus
);
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_q;

   // storage and read register; reset clears every word so a post-reset scan reads 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rd_q <= '0;
      end else if (bus.we) begin
         mem[bus.addr] <= bus.data;
      end else if (bus.re) begin
         rd_q <= mem[bus.addr];
      end
   end

   // output enable is purely combinational so releasing re or raising we frees the bus at once
   assign bus.ram_oe   = bus.re & ~bus.we & ~rst;
   assign bus.ram_dout = rd_q;
endmodule

// File: tb/tb_ram.sv
// Directed bench for ram: reset scan, write walk, re+we collision,
// bus release, boundary addresses and asynchronous reset mid-operation.
module tb_ram;
   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   ram_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) bus ();

   ram #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .DEPTH(512)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // one read: present address, edge, then expect bus driven with the word
   task automatic rd(input logic [8:0] a, input logic [31:0] exp, input string tag);
      bus.re = 1'b1; bus.we = 1'b0; bus.mst_oe = 1'b0; bus.addr = a;
      @(posedge clk); #1;
      chk({tag, "_oe"}, {31'd0, bus.ram_oe}, 32'd1);
      chk(tag, bus.data, exp);
   endtask

   // one write: master drives the bus, RAM must stay off it
   task automatic wr(input logic [8:0] a, input logic [31:0] v, input logic re_v, input string tag);
      bus.re = re_v; bus.we = 1'b1; bus.mst_oe = 1'b1; bus.mst_dout = v; bus.addr = a;
      #1 chk({tag, "_oe"}, {31'd0, bus.ram_oe}, 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      bus.re = 1'b1; bus.we = 1'b0; bus.addr = '0;
      bus.mst_oe = 1'b0; bus.mst_dout = '0;
      #1 chk("rst_oe", {31'd0, bus.ram_oe}, 32'd0);
      @(posedge clk); @(negedge clk);
      rst = 1'b0;

      // reset scan
      for (int i = 0; i < 5; i++) rd(9'(i), 32'd0, $sformatf("scan0_%0d", i));

      // write walk then read back
      for (int i = 0; i < 5; i++) wr(9'(i), 32'd1 << i, 1'b0, $sformatf("wwalk_%0d", i));
      for (int i = 0; i < 5; i++) rd(9'(i), 32'd1 << i, $sformatf("rwalk_%0d", i));

      // re+we together: a write, rd_q holds its last value (16 from addr 4)
      wr(9'd3, 32'hDEADBEEF, 1'b1, "both");
      bus.we = 1'b0; bus.mst_oe = 1'b0;
      #1 chk("both_hold", bus.data, 32'd16);
      rd(9'd3, 32'hDEADBEEF, "both_rd");

      // bus release during a read of addr 1
      rd(9'd1, 32'd2, "rel_rd");
      bus.re = 1'b0;
      #1 chk("rel_off", {31'd0, bus.ram_oe}, 32'd0);
      bus.re = 1'b1;
      #1 chk("rel_on", bus.data, 32'd2);

      // boundary addresses
      wr(9'd511, 32'hA5A5A5A5, 1'b0, "hi_w");
      wr(9'd0,   32'h5A5A5A5A, 1'b0, "lo_w");
      rd(9'd511, 32'hA5A5A5A5, "hi_rd");
      rd(9'd0,   32'h5A5A5A5A, "lo_rd");

      // rewrite walk, then async reset mid-read
      for (int i = 0; i < 5; i++) wr(9'(i), 32'd1 << i, 1'b0, $sformatf("w2_%0d", i));
      rd(9'd2, 32'd4, "pre_rst");
      #1 rst = 1'b1;
      #1 chk("mid_rst_oe", {31'd0, bus.ram_oe}, 32'd0);
      #1 rst = 1'b0;
      #1 chk("post_rst_q", bus.data, 32'd0);
      for (int i = 0; i < 5; i++) rd(9'(i), 32'd0, $sformatf("scan1_%0d", i));
      rd(9'd511, 32'd0, "scan1_511");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
